// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks req/done to a variable-latency
// instruction memory, holds one instruction for decode, handles redirects and HALT.
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'b0000100000000000,
  parameter logic [4:0]  HALT_OPC  = 5'b00000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_done,
  input  logic        stall_in,
  input  logic        redirect_in,
  input  logic [15:0] redirect_pc,
  output logic [15:0] instr_out,
  output logic [15:0] pc_out,
  output logic        valid_out,
  output logic        imem_stall_out,
  output logic        halted,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_FULL  = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] req_addr_q, req_addr_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pcout_q, pcout_d;
  logic        squash_q, squash_d;
  logic        valid_q, valid_d;

  logic [15:0] pc_plus2;
  logic [15:0] redirect_tgt;

  assign pc_plus2     = pc_q + 16'd2;
  assign redirect_tgt = redirect_pc & 16'hFFFE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pcout_q    <= 16'h0000;
      squash_q   <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      instr_q    <= instr_d;
      pcout_q    <= pcout_d;
      squash_q   <= squash_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    instr_d    = instr_q;
    pcout_d    = pcout_q;
    squash_d   = squash_q;
    valid_d    = valid_q;
    if (redirect_in) begin
      pc_d    = redirect_tgt;
      valid_d = 1'b0;
      state_d = S_FETCH;
      if (state_q == S_FETCH) begin
        if (imem_done) begin
          squash_d = 1'b0;
        end else begin
          // Freeze the in-flight address; a second redirect keeps the first one.
          squash_d = 1'b1;
          if (!squash_q) req_addr_d = pc_q;
        end
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_done) begin
            if (squash_q) begin
              squash_d = 1'b0;
            end else begin
              instr_d = imem_data;
              pcout_d = pc_plus2;
              valid_d = 1'b1;
              if (imem_data[15:11] == HALT_OPC) begin
                state_d = S_HALT;
              end else begin
                pc_d    = pc_plus2;
                state_d = S_FULL;
              end
            end
          end
        end
        S_FULL: begin
          if (!stall_in) begin
            valid_d = 1'b0;
            state_d = S_FETCH;
          end
        end
        S_HALT: begin
          if (!stall_in) valid_d = 1'b0;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  // Request is suppressed while reset is held so it first rises after reset drops.
  always_comb begin
    imem_req       = (state_q == S_FETCH) && !rst;
    imem_addr      = squash_q ? req_addr_q : pc_q;
    valid_out      = valid_q;
    instr_out      = valid_q ? instr_q : NOP_INSTR;
    pc_out         = valid_q ? pcout_q : 16'h0000;
    imem_stall_out = ~valid_q;
    halted         = (state_q == S_HALT);
    dbg_state      = state_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural memory, address/data scoreboard monitor,
// a vector table of fetches, and hand-written redirect/halt/reset sequences.
module tb_fetch_unit;

  localparam logic [15:0] NOP = 16'b0000100000000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_done;
  logic        stall_in;
  logic        redirect_in;
  logic [15:0] redirect_pc;
  logic [15:0] instr_out;
  logic [15:0] pc_out;
  logic        valid_out;
  logic        imem_stall_out;
  logic        halted;
  logic [1:0]  dbg_state;

  logic        mem_done, man_done, mem_en;
  logic [15:0] mem_data, man_data;
  int          mem_lat;
  int          cnt;
  logic [15:0] mem [logic [15:0]];

  logic [31:0] exp_q[$];
  logic [15:0] addr_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        redir;
    logic [15:0] target;
    logic [15:0] data;
    int          lat;
    int          hold;
    logic [15:0] exp_addr;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t tbl[6];

  always #5 clk = ~clk;

  assign imem_done = mem_done | man_done;
  assign imem_data = man_done ? man_data : mem_data;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_data(imem_data), .imem_done(imem_done),
    .stall_in(stall_in), .redirect_in(redirect_in), .redirect_pc(redirect_pc),
    .instr_out(instr_out), .pc_out(pc_out), .valid_out(valid_out),
    .imem_stall_out(imem_stall_out), .halted(halted), .dbg_state(dbg_state)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string nm, input logic [15:0] val);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %h expected nothing (t=%0t)", nm, val, $time);
  endtask

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return 16'hFFFF;
  endfunction

  // Memory: done in the mem_lat-th cycle of each request.
  initial begin
    mem_done = 1'b0;
    mem_data = 16'h0000;
    cnt      = 0;
    forever begin
      @(negedge clk); #1;
      if (rst || !imem_req) begin
        cnt      = 0;
        mem_done = 1'b0;
      end else begin
        if (mem_done) cnt = 0;
        cnt++;
        if (mem_en && cnt == mem_lat) begin
          mem_done = 1'b1;
          mem_data = mem_rd(imem_addr);
        end else begin
          mem_done = 1'b0;
        end
      end
    end
  end

  // Monitor: request addresses and presented instructions against the queues.
  initial begin
    logic        prev_req, prev_done, prev_valid;
    logic [15:0] prev_addr;
    logic [31:0] e;
    prev_req = 1'b0; prev_done = 1'b0; prev_valid = 1'b0; prev_addr = 16'h0;
    forever begin
      @(negedge clk); #2;
      if (rst) begin
        prev_req = 1'b0; prev_done = 1'b0; prev_valid = 1'b0;
      end else begin
        check("stall_out", {31'b0, imem_stall_out}, {31'b0, ~valid_out});
        check("req_with_valid", {31'b0, imem_req & valid_out}, 32'd0);
        if (!valid_out) begin
          check("idle_instr", {16'b0, instr_out}, {16'b0, NOP});
          check("idle_pc", {16'b0, pc_out}, 32'd0);
        end
        if (imem_req && (!prev_req || prev_done)) begin
          if (addr_q.size() == 0) unexpected("unexpected_req", imem_addr);
          else check("req_addr", {16'b0, imem_addr}, {16'b0, addr_q.pop_front()});
        end else if (imem_req && prev_req) begin
          check("addr_stable", {16'b0, imem_addr}, {16'b0, prev_addr});
        end
        if (valid_out && !prev_valid) begin
          if (exp_q.size() == 0) unexpected("unexpected_instr", instr_out);
          else begin
            e = exp_q.pop_front();
            check("sb_instr", {16'b0, instr_out}, {16'b0, e[31:16]});
            check("sb_pc", {16'b0, pc_out}, {16'b0, e[15:0]});
          end
        end
        prev_req = imem_req; prev_done = imem_done;
        prev_valid = valid_out; prev_addr = imem_addr;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_valid(input int max, input string nm);
    int n = 0;
    do begin
      @(negedge clk); #3;
      n++;
    end while (!valid_out && n < max);
    check(nm, {31'b0, valid_out}, 32'd1);
  endtask

  task automatic pulse_redirect(input logic [15:0] t);
    @(negedge clk);
    redirect_in = 1'b1;
    redirect_pc = t;
    @(negedge clk);
    redirect_in = 1'b0;
  endtask

  task automatic release_stall();
    @(negedge clk);
    stall_in = 1'b0;
    @(negedge clk);
    stall_in = 1'b1;
  endtask

  initial begin
    tbl[0] = '{1'b1, 16'h0201, 16'h1111, 1, 2, 16'h0200, 16'h0202};
    tbl[1] = '{1'b0, 16'h0000, 16'h2222, 3, 0, 16'h0202, 16'h0204};
    tbl[2] = '{1'b1, 16'hFFFF, 16'h3333, 2, 1, 16'hFFFE, 16'h0000};
    tbl[3] = '{1'b0, 16'h0000, 16'h4444, 4, 3, 16'h0000, 16'h0002};
    tbl[4] = '{1'b1, 16'h0011, 16'hF800, 2, 0, 16'h0010, 16'h0012};
    tbl[5] = '{1'b0, 16'h0000, 16'h0800, 1, 1, 16'h0012, 16'h0014};

    rst = 1'b1; stall_in = 1'b0; redirect_in = 1'b0; redirect_pc = 16'h0;
    man_done = 1'b0; man_data = 16'h0; mem_en = 1'b1; mem_lat = 1;

    // Reset state, then two back-to-back 1-cycle fetches with no stall.
    mem[16'h0000] = 16'h1234;
    mem[16'h0002] = 16'h5678;
    addr_q.push_back(16'h0000); addr_q.push_back(16'h0002);
    exp_q.push_back({16'h1234, 16'h0002}); exp_q.push_back({16'h5678, 16'h0004});
    @(negedge clk); #3;
    check("rst_valid", {31'b0, valid_out}, 32'd0);
    check("rst_instr", {16'b0, instr_out}, {16'b0, NOP});
    check("rst_pc", {16'b0, pc_out}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_stall_out", {31'b0, imem_stall_out}, 32'd1);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #3;
    check("t1_valid0", {31'b0, valid_out}, 32'd0);
    check("t1_req0", {31'b0, imem_req}, 32'd1);
    check("t1_addr0", {16'b0, imem_addr}, 32'h0000);
    @(negedge clk); #3;
    check("t1_valid1", {31'b0, valid_out}, 32'd1);
    check("t1_instr1", {16'b0, instr_out}, 32'h1234);
    check("t1_pc1", {16'b0, pc_out}, 32'h0002);
    @(negedge clk); #3;
    check("t1_valid2", {31'b0, valid_out}, 32'd0);
    check("t1_addr2", {16'b0, imem_addr}, 32'h0002);
    @(negedge clk); #3;
    check("t1_valid3", {31'b0, valid_out}, 32'd1);
    check("t1_instr3", {16'b0, instr_out}, 32'h5678);
    stall_in = 1'b1;

    // Stall held four cycles while FULL.
    mem[16'h0100] = 16'hABCD;
    addr_q.push_back(16'h0100); exp_q.push_back({16'hABCD, 16'h0102});
    pulse_redirect(16'h0100);
    wait_valid(10, "stall_wait");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #3;
      check("stall_instr", {16'b0, instr_out}, 32'hABCD);
      check("stall_valid", {31'b0, valid_out}, 32'd1);
      check("stall_req", {31'b0, imem_req}, 32'd0);
    end
    mem[16'h0102] = 16'hBEEF;
    addr_q.push_back(16'h0102); exp_q.push_back({16'hBEEF, 16'h0104});
    release_stall();
    #3;
    check("stall_next_addr", {16'b0, imem_addr}, 32'h0102);
    wait_valid(10, "stall_next_wait");

    // Table of fetches, each starting from a parked (stalled, FULL) pipeline.
    for (int r = 0; r < 6; r++) begin
      mem[tbl[r].exp_addr] = tbl[r].data;
      mem_lat = tbl[r].lat;
      addr_q.push_back(tbl[r].exp_addr);
      exp_q.push_back({tbl[r].data, tbl[r].exp_pc});
      if (tbl[r].redir) pulse_redirect(tbl[r].target);
      else release_stall();
      wait_valid(tbl[r].lat + 10, "tbl_wait");
      check("tbl_instr", {16'b0, instr_out}, {16'b0, tbl[r].data});
      check("tbl_pc", {16'b0, pc_out}, {16'b0, tbl[r].exp_pc});
      for (int h = 0; h < tbl[r].hold; h++) begin
        @(negedge clk); #3;
        check("tbl_hold", {16'b0, instr_out}, {16'b0, tbl[r].data});
      end
    end

    // Redirect in the 2nd wait cycle of a 5-cycle fetch: squash.
    mem_lat = 5;
    mem[16'h0014] = 16'h5555;
    mem[16'h0040] = 16'h6666;
    addr_q.push_back(16'h0014); addr_q.push_back(16'h0040);
    exp_q.push_back({16'h6666, 16'h0042});
    release_stall();
    #3;
    check("sq_addr_f1", {16'b0, imem_addr}, 32'h0014);
    pulse_redirect(16'h0041);
    #3;
    check("sq_addr_hold", {16'b0, imem_addr}, 32'h0014);
    check("sq_req_hold", {31'b0, imem_req}, 32'd1);
    wait_valid(20, "sq_wait");

    // Redirect coincident with done: data dropped, no squash.
    mem_lat = 2;
    mem[16'h0042] = 16'h7777;
    mem[16'h0080] = 16'h8888;
    addr_q.push_back(16'h0042); addr_q.push_back(16'h0080);
    exp_q.push_back({16'h8888, 16'h0082});
    release_stall();
    begin
      int n = 0;
      #3;
      while (!imem_done && n < 10) begin
        @(negedge clk); #3;
        n++;
      end
    end
    check("rd_done_seen", {31'b0, imem_done}, 32'd1);
    redirect_in = 1'b1;
    redirect_pc = 16'h0080;
    mem_lat = 1;
    @(negedge clk);
    redirect_in = 1'b0;
    #3;
    check("rd_next_req", {31'b0, imem_req}, 32'd1);
    check("rd_next_addr", {16'b0, imem_addr}, 32'h0080);
    check("rd_valid", {31'b0, valid_out}, 32'd0);
    wait_valid(10, "rd_wait");

    // Stray done while no request is outstanding.
    @(negedge clk);
    man_done = 1'b1; man_data = 16'h9999;
    @(negedge clk);
    man_done = 1'b0;
    #3;
    check("stray_instr", {16'b0, instr_out}, 32'h8888);
    check("stray_valid", {31'b0, valid_out}, 32'd1);
    check("stray_req", {31'b0, imem_req}, 32'd0);

    // HALT fetched at 0x0010.
    mem[16'h0010] = 16'h0000;
    addr_q.push_back(16'h0010); exp_q.push_back({16'h0000, 16'h0012});
    pulse_redirect(16'h0010);
    wait_valid(10, "halt_wait");
    check("halt_pc", {16'b0, pc_out}, 32'h0012);
    check("halt_flag", {31'b0, halted}, 32'd1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      stall_in = (i == 0) ? 1'b0 : 1'b1;
      #3;
      check("halt_req", {31'b0, imem_req}, 32'd0);
      check("halt_hold", {31'b0, halted}, 32'd1);
      if (i >= 1) check("halt_consumed", {31'b0, valid_out}, 32'd0);
    end
    mem[16'h0020] = 16'hA0A0;
    addr_q.push_back(16'h0020); exp_q.push_back({16'hA0A0, 16'h0022});
    pulse_redirect(16'h0020);
    #3;
    check("unhalt_flag", {31'b0, halted}, 32'd0);
    check("unhalt_req", {31'b0, imem_req}, 32'd1);
    check("unhalt_addr", {16'b0, imem_addr}, 32'h0020);
    wait_valid(10, "unhalt_wait");

    // Reset during an outstanding request, late done while reset is held.
    mem_en = 1'b0;
    addr_q.push_back(16'h0022);
    release_stall();
    #3;
    check("rr_addr", {16'b0, imem_addr}, 32'h0022);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    man_done = 1'b1; man_data = 16'hDEAD;
    #3;
    check("rr_valid", {31'b0, valid_out}, 32'd0);
    check("rr_req", {31'b0, imem_req}, 32'd0);
    check("rr_instr", {16'b0, instr_out}, {16'b0, NOP});
    check("rr_halted", {31'b0, halted}, 32'd0);
    mem[16'h0000] = 16'hC0DE;
    addr_q.push_back(16'h0000); exp_q.push_back({16'hC0DE, 16'h0002});
    @(negedge clk);
    rst = 1'b0; man_done = 1'b0; mem_en = 1'b1; mem_lat = 2;
    #3;
    check("rr_first_req", {31'b0, imem_req}, 32'd1);
    check("rr_first_addr", {16'b0, imem_addr}, 32'h0000);
    check("rr_first_valid", {31'b0, valid_out}, 32'd0);
    wait_valid(10, "rr_wait");
    check("rr_instr_ok", {16'b0, instr_out}, 32'hC0DE);
    check("rr_pc_ok", {16'b0, pc_out}, 32'h0002);

    @(negedge clk); #3;
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("addr_q_drained", addr_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
